// File: rtl/demux1_4_route.sv
// 1-to-4 valid/ready demultiplexer.
// Each channel has a one-word holding register and a delivery counter.
module demux1_4_route #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data0,
  output logic [31:0]      out_data1,
  output logic [31:0]      out_data2,
  output logic [31:0]      out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e        r_state [4];
  logic [31:0]      r_data  [4];
  logic [CNT_W-1:0] r_cnt   [4];

  logic       w_accept;
  logic [3:0] w_load;
  logic [3:0] w_deliv;

  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load = 4'b0000;
    unique case (1'b1)
      (in_sel == 2'd0): w_load[0] = w_accept;
      (in_sel == 2'd1): w_load[1] = w_accept;
      (in_sel == 2'd2): w_load[2] = w_accept;
      (in_sel == 2'd3): w_load[3] = w_accept;
    endcase
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    assign out_valid[k] = (r_state[k] == FULL);
    assign w_deliv[k]   = out_valid[k] & out_ready[k];

    // A same-edge load wins over delivery so the channel stays FULL.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state[k] <= EMPTY;
        r_data[k]  <= '0;
        r_cnt[k]   <= '0;
      end else begin
        case (r_state[k])
          EMPTY: begin
            if (w_load[k]) begin
              r_data[k]  <= in_data;
              r_state[k] <= FULL;
            end
          end
          FULL: begin
            if (w_load[k]) begin
              r_data[k]  <= in_data;
              r_state[k] <= FULL;
            end else if (out_ready[k]) begin
              r_state[k] <= EMPTY;
            end
          end
          default: r_state[k] <= EMPTY;
        endcase
        if (w_deliv[k]) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
        end
      end
    end
  end

  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];

endmodule

// File: tb/tb_demux1_4_route.sv
// Bench for demux1_4_route: vector table, scoreboard queues,
// throughput, counter wrap and asynchronous reset sequences.
module tb_demux1_4_route;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      in_data = '0;
  logic [1:0]       in_sel = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      d0, d1, d2, d3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = '0;
  logic [CNT_W-1:0] c0, c1, c2, c3;

  demux1_4_route #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data0 (d0),
    .out_data1 (d1),
    .out_data2 (d2),
    .out_data3 (d3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt0      (c0),
    .cnt1      (c1),
    .cnt2      (c2),
    .cnt3      (c3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]      q [4][$];
  logic [3:0]       m_valid;
  logic [31:0]      m_data [4];
  logic [CNT_W-1:0] m_cnt [4];
  logic             last_rdy;

  typedef struct {
    logic        v;
    logic [1:0]  s;
    logic [31:0] d;
    logic [3:0]  r;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_d(input int k);
    case (k)
      0: return d0;
      1: return d1;
      2: return d2;
      default: return d3;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] dut_c(input int k);
    case (k)
      0: return c0;
      1: return c1;
      2: return c2;
      default: return c3;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = '0;
    for (int k = 0; k < 4; k++) begin
      m_data[k] = '0;
      m_cnt[k]  = '0;
      q[k].delete();
    end
  endtask

  task automatic chk_cnts(input string nm);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s_cnt%0d", nm, k), 32'(dut_c(k)), 32'(m_cnt[k]));
    end
  endtask

  // One clock: drive, check at negedge, update model, pass the edge.
  task automatic cycle(input logic v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] r);
    logic        mr;
    logic [31:0] e;
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    mr = ~m_valid[s] | r[s];
    last_rdy = in_ready;
    chk("in_ready", 32'(in_ready), 32'(mr));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold%0d", k), dut_d(k), m_data[k]);
      if (m_valid[k] && r[k]) begin
        if (q[k].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty%0d: got delivery, expected none", k);
        end else begin
          e = q[k].pop_front();
          chk($sformatf("deliver%0d", k), dut_d(k), e);
        end
        m_cnt[k]++;
        m_valid[k] = 1'b0;
      end
    end
    if (v && mr) begin
      m_valid[s] = 1'b1;
      m_data[s]  = d;
      q[s].push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 2'd0, 32'd1,   4'b0000, 1'b1, 4'b0001};
    tbl[1]  = '{1'b1, 2'd1, 32'd2,   4'b0000, 1'b1, 4'b0011};
    tbl[2]  = '{1'b1, 2'd2, 32'd3,   4'b0000, 1'b1, 4'b0111};
    tbl[3]  = '{1'b1, 2'd3, 32'd4,   4'b0000, 1'b1, 4'b1111};
    tbl[4]  = '{1'b1, 2'd2, 32'd100, 4'b0000, 1'b0, 4'b1111};
    tbl[5]  = '{1'b1, 2'd2, 32'd100, 4'b0100, 1'b1, 4'b1111};
    tbl[6]  = '{1'b1, 2'd1, 32'd7,   4'b0001, 1'b0, 4'b1110};
    tbl[7]  = '{1'b0, 2'd0, 32'd0,   4'b1111, 1'b1, 4'b0000};
    tbl[8]  = '{1'b1, 2'd0, 32'd9,   4'b0000, 1'b1, 4'b0001};
    tbl[9]  = '{1'b1, 2'd1, 32'd10,  4'b0000, 1'b1, 4'b0011};
    tbl[10] = '{1'b0, 2'd0, 32'd0,   4'b0011, 1'b1, 4'b0000};

    model_reset();

    // Reset held across edges with a valid source: nothing loads.
    in_valid = 1'b1;
    in_sel   = 2'd0;
    in_data  = 32'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_d0", d0, 32'd0);
    chk_cnts("rst");
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
      chk($sformatf("tbl%0d_rdy", i), 32'(last_rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].exp_ov));
      if (i == 3) begin
        chk("route_d0", d0, 32'd1);
        chk("route_d3", d3, 32'd4);
        chk_cnts("route");
      end
      if (i == 4) chk("bp_d2", d2, 32'd3);
      if (i == 5) begin
        chk("bp_d2_new", d2, 32'd100);
        chk("bp_cnt2", 32'(c2), 32'd1);
      end
      if (i == 9) chk("indep_d0", d0, 32'd9);
    end
    chk_cnts("tbl");

    // Full-rate streaming on channel 3.
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 2'd3, 32'(i), 4'b1000);
    end
    cycle(1'b0, 2'd3, 32'd0, 4'b1000);
    chk_cnts("thru");

    // Counter wrap after exactly 256 deliveries on channel 0.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 2'd0, 32'(i + 1000), 4'b0001);
    end
    cycle(1'b0, 2'd0, 32'd0, 4'b0001);
    chk("wrap_cnt0", 32'(c0), 32'd0);
    chk_cnts("wrap");

    // Async reset between edges with all channels FULL.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 2'(k), 32'(k + 40), 4'b0000);
    end
    chk("pre_rst_ov", 32'(out_valid), 32'hf);
    in_valid = 1'b1;
    in_sel   = 2'd1;
    in_data  = 32'h77;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("arst_d%0d", k), dut_d(k), 32'd0);
    end
    model_reset();
    chk_cnts("arst");
    @(posedge clk);
    #1;
    chk("arst_hold_ov", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    cycle(1'b1, 2'd2, 32'hab, 4'b0000);
    cycle(1'b0, 2'd0, 32'd0, 4'b0100);
    chk_cnts("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux1_4_route.md
DEMUX1_4_ROUTE -- requirements
Module: demux1_4_route

Interface
REQ-001 Parameter CNT_W, default 8: width of each per-channel delivery counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_data  input  32  source word to route.
REQ-005 in_sel  input  2  destination channel index, 0..3; 2'd0 selects channel 0, 2'd3 selects channel 3.
REQ-006 in_valid  input  1  source asserts that in_data and in_sel are valid.
REQ-007 in_ready  output  1  block can accept the source word this cycle.
REQ-008 out_data0, out_data1, out_data2, out_data3  output  32 each  channel holding-register contents.
REQ-009 out_valid  output  4  bit k means channel k holds an undelivered word.
REQ-010 out_ready  input  4  bit k means the channel-k sink accepts this cycle.
REQ-011 cnt0, cnt1, cnt2, cnt3  output  CNT_W each  words delivered per channel.

Function
REQ-012 Each channel k SHALL have a one-entry 32-bit holding register and a two-state FSM: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-013 in_ready SHALL be combinational: ~out_valid[in_sel] | out_ready[in_sel].
REQ-014 Accept condition: in_valid & in_ready at a rising edge.
- On accept, the holding register of channel in_sel SHALL load in_data.
- On accept, out_valid[in_sel] SHALL be 1 in the next cycle.
REQ-015 Latency: an accepted word SHALL appear on out_dataK with out_valid[K]=1 exactly one cycle after the accept edge.
REQ-016 Delivery condition for channel k: out_valid[k] & out_ready[k] at a rising edge.
- On delivery with no same-edge load, channel k SHALL return to EMPTY.
REQ-017 Simultaneous delivery and load on the same channel SHALL keep channel k FULL with the new word.
- This provides full throughput of one word per cycle per channel.
- No word SHALL be lost or duplicated.
REQ-018 Loads to channel j and deliveries on other channels k≠j SHALL proceed independently in the same cycle.
REQ-019 At most one channel SHALL be loaded per cycle.
- Channels not selected by in_sel SHALL hold their data and state.
REQ-020 The holding register SHALL NOT change while out_valid[k]=1 and out_ready[k]=0.
REQ-021 out_valid[k] SHALL NOT deassert without a delivery.
REQ-022 cntK SHALL increment by 1 on each channel-k delivery.
- Counters SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-023 The source SHALL hold in_data and in_sel stable while in_valid=1 and in_ready=0.
- The block SHALL NOT check this rule.
REQ-024 When in_valid=0, no channel state or data SHALL change except through deliveries.
REQ-025 out_dataK of an EMPTY channel SHALL retain the last loaded value (0 after reset).
- The sink SHALL ignore it.

Reset
REQ-026 Asserting rst_n=0 SHALL immediately, without waiting for clk, set:
- out_valid=4'b0000;
- out_data0..3=32'd0;
- cnt0..3=0.
REQ-027 With out_valid=0 during reset, in_ready SHALL evaluate to 1.
- No accept or delivery SHALL take effect while rst_n=0.
REQ-028 Reset asserted mid-transfer SHALL discard all held words.
- After rst_n returns to 1, operation SHALL resume from all-EMPTY at the first rising edge.

Verification
REQ-029 Routing: out_ready=4'b0000; in_valid=1 with (sel,data) = (0,1), (1,2), (2,3), (3,4) on consecutive edges -> out_data0..3 = 1, 2, 3, 4; out_valid=4'b1111; cnt all 0.
REQ-030 Backpressure: channel 2 FULL with 3, out_ready[2]=0, in_sel=2, in_data=100 -> in_ready=0; out_data2 stays 3. Then out_ready[2]=1 -> same edge delivers 3 and loads 100; out_data2=100; cnt2=1.
REQ-031 Throughput: in_sel=3, out_ready[3]=1, in_valid=1 for 10 cycles with data 1..10 -> one word delivered per cycle after 1-cycle latency; cnt3=10; ordering preserved.
REQ-032 Independence: channel 0 FULL and stalled, in_sel=1 -> in_ready=1 and channel 1 loads while out_data0 is unchanged.
REQ-033 Counter wrap: 256 deliveries on channel 0 with CNT_W=8 -> cnt0=0.
REQ-034 Async reset: drop rst_n between edges with all channels FULL -> out_valid=0, all data and counters 0 before the next edge.
